// File: rtl/result_trace_fifo.sv
// Result trace FIFO: captures retired writeback results ({rd, data}) for an
// external trace consumer. The input side never stalls; results that arrive
// while the FIFO is full are dropped and recorded in a sticky overflow flag.
// The head entry is presented first-word-fall-through.
module result_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data,
    input  logic [4:0]               in_rd,
    input  logic                     out_ready,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [4:0]               out_rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              commit_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DW + 5;

    // Reject depths that are not a power of two in the supported range
    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("result_trace_fifo: DEPTH must be a power of two from 2 to 64");
    end

    // Pointers carry an extra wrap bit above the index
    logic [AW:0]   head;
    logic [AW:0]   tail;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head_entry;

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    // Occupancy status and handshake decode
    always_comb begin
        empty_c = (head == tail);
        full_c  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
        pop_c   = !empty_c && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        push_c  = in_valid && (!full_c || pop_c);
        drop_c  = in_valid && full_c && !pop_c;
    end

    // Storage array: written on accepted pushes only, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[tail[AW-1:0]] <= {in_rd, in_data};
        end
    end

    // Head/tail pointer advance
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push_c) begin
                tail <= tail + (AW + 1)'(1);
            end
            if (pop_c) begin
                head <= head + (AW + 1)'(1);
            end
        end
    end

    // Sticky overflow: a new drop wins over a simultaneous clear
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Count of accepted results, free-running with natural 32-bit wrap
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            commit_cnt <= '0;
        end else if (push_c) begin
            commit_cnt <= commit_cnt + 32'd1;
        end
    end

    // Head presentation; stale array contents are masked while empty
    always_comb begin
        head_entry = mem[head[AW-1:0]];
        out_valid  = !empty_c;
        out_data   = '0;
        out_rd     = '0;
        if (!empty_c) begin
            out_data = head_entry[DW-1:0];
            out_rd   = head_entry[EW-1:DW];
        end
        count = tail - head;
    end

endmodule

// File: tb/tb_result_trace_fifo.sv
// Directed bench for result_trace_fifo (DEPTH=8, DW=32, 100 ns clock).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_result_trace_fifo;

    logic        clk;
    logic        Rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        out_ready;
    logic        ovf_clr;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [3:0]  count;
    logic        overflow;
    logic [31:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    result_trace_fifo #(.DEPTH(8), .DW(32)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_rd      (in_rd),
        .out_ready  (out_ready),
        .ovf_clr    (ovf_clr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .count      (count),
        .overflow   (overflow),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"},  64'(out_valid), 64'd0);
        check({tag, "_count"},  64'(count), 64'd0);
        check({tag, "_commit"}, 64'(commit_cnt), 64'd0);
        check({tag, "_ovf"},    64'(overflow), 64'd0);
        check({tag, "_data"},   64'(out_data), 64'd0);
        check({tag, "_rd"},     64'(out_rd), 64'd0);
    endtask

    initial begin
        Rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset held for 110 ns
        #10;
        check_idle("rst_t10");
        @(negedge clk);
        check_idle("rst_t100");
        #10 Rst = 1'b1;
        @(negedge clk);
        check_idle("rst_release");

        // Ordering: three pushes with out_ready low
        in_valid = 1'b1; in_data = 32'h1111_1111; in_rd = 5'd1;
        @(negedge clk);
        check("fwft_valid", 64'(out_valid), 64'd1);
        check("fwft_data",  64'(out_data), 64'h1111_1111);
        check("fwft_rd",    64'(out_rd), 64'd1);
        check("fwft_count", 64'(count), 64'd1);
        in_data = 32'h2222_2222; in_rd = 5'd2;
        @(negedge clk);
        in_data = 32'h3333_3333; in_rd = 5'd3;
        @(negedge clk);
        check("ord_count3", 64'(count), 64'd3);
        check("ord_head1",  64'(out_data), 64'h1111_1111);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("ord_head2", 64'(out_data), 64'h2222_2222);
        check("ord_rd2",   64'(out_rd), 64'd2);
        check("ord_cnt2",  64'(count), 64'd2);
        @(negedge clk);
        check("ord_head3", 64'(out_data), 64'h3333_3333);
        check("ord_rd3",   64'(out_rd), 64'd3);
        @(negedge clk);
        check("ord_empty_valid", 64'(out_valid), 64'd0);
        check("ord_empty_data",  64'(out_data), 64'd0);
        check("ord_commit",      64'(commit_cnt), 64'd3);
        @(negedge clk);
        check("pop_empty_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Fill: 9 pushes into 8 entries
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(i); in_rd = 5'(i);
            @(negedge clk);
            if (i == 7) begin
                check("fill8_count", 64'(count), 64'd8);
                check("fill8_ovf",   64'(overflow), 64'd0);
            end
        end
        check("full_count",  64'(count), 64'd8);
        check("full_ovf",    64'(overflow), 64'd1);
        check("full_commit", 64'(commit_cnt), 64'd11);
        check("full_head",   64'(out_data), 64'h100);
        check("full_rd",     64'(out_rd), 64'd0);

        // Simultaneous push and pop while full
        in_data = 32'hAAAA_0000; in_rd = 5'd31; out_ready = 1'b1;
        @(negedge clk);
        check("sim_count",  64'(count), 64'd8);
        check("sim_ovf",    64'(overflow), 64'd1);
        check("sim_commit", 64'(commit_cnt), 64'd12);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) check("drain_data", 64'(out_data), 64'h101 + 64'(k));
            else       check("drain_last", 64'(out_data), 64'hAAAA_0000);
            @(negedge clk);
        end
        check("drain_count", 64'(count), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Overflow clear, then clear colliding with a new drop
        ovf_clr = 1'b1;
        @(negedge clk);
        check("ovf_clr", 64'(overflow), 64'd0);
        ovf_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 32'h200 + 32'(i); in_rd = 5'(i + 8);
            @(negedge clk);
        end
        check("refill_ovf", 64'(overflow), 64'd0);
        ovf_clr = 1'b1; in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("clr_vs_drop_ovf",   64'(overflow), 64'd1);
        check("clr_vs_drop_count", 64'(count), 64'd8);
        check("clr_vs_drop_commit", 64'(commit_cnt), 64'd20);
        in_valid = 1'b0;
        @(negedge clk);
        check("ovf_clr2", 64'(overflow), 64'd0);
        ovf_clr = 1'b0;

        // Drain three to reach count 5
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        check("pre_rst_count", 64'(count), 64'd5);
        check("pre_rst_head",  64'(out_data), 64'h203);
        check("pre_rst_rd",    64'(out_rd), 64'd11);

        // Asynchronous reset between clock edges
        #10 Rst = 1'b0;
        #1;
        check_idle("async_rst");
        #10 Rst = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // Push and pop together while empty: push only, no bypass
        in_valid = 1'b1; in_data = 32'h5; in_rd = 5'd5; out_ready = 1'b1;
        @(negedge clk);
        check("emp_pp_valid",  64'(out_valid), 64'd1);
        check("emp_pp_data",   64'(out_data), 64'h5);
        check("emp_pp_rd",     64'(out_rd), 64'd5);
        check("emp_pp_count",  64'(count), 64'd1);
        check("emp_pp_commit", 64'(commit_cnt), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("emp_pp_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_trace_fifo.md
RESULT_TRACE_FIFO -- requirements
Module: result_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, sets FIFO entries; legal values are powers of two from 2 to 64.
REQ-002 Parameter DW, default 32, sets the result data width.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 in_valid  input  1  writeback stage retires a result this cycle.
REQ-006 in_data  input  DW  retired result value, the same value the CPU drives on resultbuf.
REQ-007 in_rd  input  5  destination register number of the retired result.
REQ-008 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-009 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-010 out_valid  output  1  FIFO holds at least one entry.
REQ-011 out_data  output  DW  head entry data.
REQ-012 out_rd  output  5  head entry register number.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky flag: at least one result dropped.
REQ-015 commit_cnt  output  32  total results accepted since reset.

Function
REQ-016 The block sits downstream of the pipeline writeback; the input side has no backpressure, because the CPU cannot stall on trace.
REQ-017 Push: in_valid=1 and (count<DEPTH, or a pop occurs in the same cycle) writes {in_rd,in_data} at the tail and advances the tail pointer modulo DEPTH.
REQ-018 Pop: out_valid=1 and out_ready=1 advances the head pointer modulo DEPTH; out_ready while empty has no effect.
REQ-019 First-word fall-through: an entry pushed at edge N appears on out_data/out_rd with out_valid=1 after edge N (latency one cycle).
REQ-020 When empty, out_data and out_rd are 0.
REQ-021 Push and pop in the same cycle at any occupancy from 1 to DEPTH both succeed and count is unchanged.
REQ-022 Push and pop in the same cycle while empty: only the push takes effect, count becomes 1, and no data is bypassed.
REQ-023 Push while count=DEPTH with no pop: the entry is dropped, overflow is set to 1, and FIFO contents and count are unchanged.
REQ-024 overflow stays set until ovf_clr=1; if ovf_clr and a new drop occur in the same cycle, overflow remains 1.
REQ-025 Each accepted push increments commit_cnt by 1; it wraps from 0xFFFFFFFF to 0, and dropped pushes do not increment it.
REQ-026 The head/tail pointers carry one extra wrap bit; full means equal indices with differing wrap bits, and empty means identical pointers.
REQ-027 count is always tail minus head, taken from the pointers, and never exceeds DEPTH.
REQ-028 The storage array is not reset; only pointers, flags and counters are reset.

Reset
REQ-029 Rst=0 immediately clears head, tail, overflow and commit_cnt, giving out_valid=0, count=0 and out_data=out_rd=0, without waiting for a clock edge.
REQ-030 Reset asserted mid-operation discards all stored entries; after release the block behaves as freshly reset.
REQ-031 Release of Rst is synchronised by the system; the first push is accepted at the first rising edge after Rst=1.

Verification
REQ-032 Reset: hold Rst=0 for 110 ns with a 100 ns clock, then release -> out_valid=0, count=0, commit_cnt=0 and overflow=0 throughout.
REQ-033 Ordering: push 0x11111111/rd 1, 0x22222222/rd 2 and 0x33333333/rd 3 with out_ready=0, then raise out_ready -> the three entries pop in that order and commit_cnt=3.
REQ-034 Full/overflow: push 9 entries with DEPTH=8 and out_ready=0 -> count=8, overflow=1, commit_cnt=8, and the head still holds the first entry.
REQ-035 Simultaneous: at count=8, push 0xAAAA0000 with out_ready=1 -> count stays 8, overflow is unchanged, and 0xAAAA0000 is the last entry drained.
REQ-036 Empty push+pop: while empty, in_valid=1 and out_ready=1 with 0x5 -> the next cycle shows out_valid=1, out_data=0x5 and count=1.
REQ-037 Async reset: assert Rst=0 between clock edges at count=5 -> count=0 and out_valid=0 before the next edge, and commit_cnt=0.
